// File: rtl/pwm_ramp_ctrl.sv
// Purpose : soft-start duty controller; ramps dc toward an accepted target by STEP per RAMP_DIV PWM periods.
// Latency : dc changes only on the pcnt 255->0 edge; done pulses one cycle after the final step or an equal-target accept.
// Backpressure: tgt_ready is high only in IDLE; targets offered while busy or faulted wait. Optional kill path: `define PWM_RAMP_FAULT_EN.
module pwm_ramp_ctrl #(
    parameter int STEP     = 5,
    parameter int RAMP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tgt_valid,
    input  logic [6:0] tgt_dc,
    output logic       tgt_ready,
    output logic [6:0] dc,
    output logic       busy,
    output logic       done,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic       fault_sts
);

`ifdef PWM_RAMP_FAULT_EN
    typedef enum logic [1:0] {IDLE, RAMP, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

    localparam logic [7:0] STEP_W   = 8'(STEP);
    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    state_t     state;
    logic [7:0] pcnt;
    logic [7:0] divcnt;
    logic [6:0] tgt;
    logic [6:0] tgt_in;
    logic [6:0] dc_next;
    logic [7:0] dc_w;
    logic [7:0] tgt_w;
    logic [7:0] up_sum;
    logic [7:0] dn_lim;

    assign tgt_ready = (state == IDLE);
    assign busy      = (state == RAMP);
    assign tgt_in    = (tgt_dc > 7'd100) ? 7'd100 : tgt_dc;

    // Next duty one step toward the target, computed at 8 bits and clamped so it never overshoots.
    always_comb begin
        dc_w   = {1'b0, dc};
        tgt_w  = {1'b0, tgt};
        up_sum = dc_w + STEP_W;
        dn_lim = tgt_w + STEP_W;
        dc_next = dc;
        if (tgt_w > dc_w) begin
            dc_next = (up_sum > tgt_w) ? tgt : up_sum[6:0];
        end else if (dc_w < dn_lim) begin
            dc_next = tgt;
        end else begin
            dc_next = 7'(dc_w - STEP_W);
        end
    end

`ifdef PWM_RAMP_FAULT_EN
    logic fault_q;
    assign fault_sts = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_in ^ fault_clr;
    assign fault_sts    = 1'b0;
`endif

    // Period counter, control FSM, duty register and done pulse; a fault overrides any same-cycle accept or step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcnt   <= 8'd0;
            divcnt <= 8'd0;
            dc     <= 7'd0;
            tgt    <= 7'd0;
            done   <= 1'b0;
`ifdef PWM_RAMP_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            pcnt <= pcnt + 8'd1;
            done <= 1'b0;
`ifdef PWM_RAMP_FAULT_EN
            if (fault_in) begin
                state   <= FAULT;
                dc      <= 7'd0;
                tgt     <= 7'd0;
                divcnt  <= 8'd0;
                fault_q <= 1'b1;
            end else
`endif
            case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        tgt <= tgt_in;
                        if (tgt_in == dc) begin
                            done <= 1'b1;
                        end else begin
                            state  <= RAMP;
                            divcnt <= 8'd0;
                        end
                    end
                end
                RAMP: begin
                    if (pcnt == 8'hFF) begin
                        if (divcnt == DIV_LAST) begin
                            divcnt <= 8'd0;
                            dc     <= dc_next;
                            if (dc_next == tgt) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            divcnt <= divcnt + 8'd1;
                        end
                    end
                end
`ifdef PWM_RAMP_FAULT_EN
                FAULT: begin
                    if (fault_clr) begin
                        state   <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (RAMP_DIV=1 and RAMP_DIV=3) checked every cycle
// against a model that precomputes each ramp as a list of duty values released on period wraps.
// Directed ramp/clamp/equal-target/fault/reset scenarios, then a randomized run.
module tb_pwm_ramp_ctrl;

`ifdef PWM_RAMP_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif
    localparam int STEP = 5;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       tv    [2];
    logic [6:0] td    [2];
    logic       fi    [2];
    logic       fc    [2];

    logic       rdy0, busy0, done0, fs0;
    logic       rdy1, busy1, done1, fs1;
    logic [6:0] dc0, dc1;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 ramping, 2 faulted
    int m_st  [2];
    int m_dc  [2];
    int m_pc  [2];
    int m_wr  [2];
    int m_done[2];
    int m_fs  [2];
    int m_seq [2][32];
    int m_len [2];
    int m_pos [2];

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.STEP(STEP), .RAMP_DIV(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .tgt_valid(tv[0]), .tgt_dc(td[0]),
        .tgt_ready(rdy0), .dc(dc0), .busy(busy0), .done(done0),
        .fault_in(fi[0]), .fault_clr(fc[0]), .fault_sts(fs0)
    );

    pwm_ramp_ctrl #(.STEP(STEP), .RAMP_DIV(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .tgt_valid(tv[1]), .tgt_dc(td[1]),
        .tgt_ready(rdy1), .dc(dc1), .busy(busy1), .done(done1),
        .fault_in(fi[1]), .fault_clr(fc[1]), .fault_sts(fs1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int get_dc(input int i);
        return (i == 0) ? int'(dc0) : int'(dc1);
    endfunction

    function automatic int get_rdy(input int i);
        return (i == 0) ? int'(rdy0) : int'(rdy1);
    endfunction

    function automatic int get_busy(input int i);
        return (i == 0) ? int'(busy0) : int'(busy1);
    endfunction

    function automatic int get_done(input int i);
        return (i == 0) ? int'(done0) : int'(done1);
    endfunction

    function automatic int get_fs(input int i);
        return (i == 0) ? int'(fs0) : int'(fs1);
    endfunction

    task automatic model_reset(input int i);
        m_st[i] = 0; m_dc[i] = 0; m_pc[i] = 0; m_wr[i] = 0;
        m_done[i] = 0; m_fs[i] = 0; m_len[i] = 0; m_pos[i] = 0;
    endtask

    // Accepted target: write out every intermediate duty the ramp should visit.
    task automatic plan_ramp(input int i, input int t);
        int v;
        v = m_dc[i];
        m_len[i] = 0;
        m_pos[i] = 0;
        while (v != t) begin
            if (t > v) v = (v + STEP > t) ? t : v + STEP;
            else       v = (v - STEP < t) ? t : v - STEP;
            m_seq[i][m_len[i]] = v;
            m_len[i]++;
        end
    endtask

    task automatic model_step(input int i);
        bit wrap;
        int t;
        if (!rst_n[i]) begin
            model_reset(i);
            return;
        end
        wrap = (m_pc[i] == 255);
        m_pc[i] = (m_pc[i] + 1) % 256;
        m_done[i] = 0;
        if (FEN && fi[i]) begin
            m_st[i] = 2; m_dc[i] = 0; m_fs[i] = 1; m_len[i] = 0; m_pos[i] = 0;
        end else if (m_st[i] == 2) begin
            if (fc[i]) begin m_st[i] = 0; m_fs[i] = 0; end
        end else if (m_st[i] == 0) begin
            if (tv[i]) begin
                t = (td[i] > 100) ? 100 : int'(td[i]);
                if (t == m_dc[i]) m_done[i] = 1;
                else begin
                    plan_ramp(i, t);
                    m_wr[i] = 0;
                    m_st[i] = 1;
                end
            end
        end else if (wrap) begin
            m_wr[i]++;
            if (m_wr[i] % div_of(i) == 0) begin
                m_dc[i] = m_seq[i][m_pos[i]];
                m_pos[i]++;
                if (m_pos[i] == m_len[i]) begin
                    m_done[i] = 1;
                    m_st[i] = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input int i);
        check_val($sformatf("u%0d_dc", i),    get_dc(i),   m_dc[i]);
        check_val($sformatf("u%0d_ready", i), get_rdy(i),  (m_st[i] == 0) ? 1 : 0);
        check_val($sformatf("u%0d_busy", i),  get_busy(i), (m_st[i] == 1) ? 1 : 0);
        check_val($sformatf("u%0d_done", i),  get_done(i), m_done[i]);
        check_val($sformatf("u%0d_fsts", i),  get_fs(i),   m_fs[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic offer(input int i, input int v);
        tv[i] = 1'b1;
        td[i] = 7'(v);
        cycle();
        tv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (m_st[i] != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (m_st[i] != 0) check_val($sformatf("u%0d_idle_timeout", i), get_rdy(i), 2);
    endtask

    task automatic wait_dc(input int i, input int v, input int budget);
        int n;
        n = 0;
        while (m_dc[i] != v && n < budget) begin
            cycle();
            n++;
        end
        if (m_dc[i] != v) check_val($sformatf("u%0d_dc_timeout", i), get_dc(i), v);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; tv[i] = 1'b0; td[i] = 7'd0; fi[i] = 1'b0; fc[i] = 1'b0;
            model_reset(i);
        end
        #2;
        check_val("rst_dc", int'(dc0), 0);
        check_val("rst_ready", int'(rdy0), 1);
        check_val("rst_busy", int'(busy0), 0);
        check_val("rst_done", int'(done0), 0);
        cycle();
        cycle();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        cycle();

        // 0 -> 20 on instance 0 while instance 1 climbs to 100 with RAMP_DIV=3
        tv[1] = 1'b1; td[1] = 7'd100;
        offer(0, 20);
        tv[1] = 1'b0;
        wait_idle(0, 2000);
        check_val("ramp20_dc", int'(dc0), 20);

        // 20 -> 95, then an over-range target clamps to 100 in one step
        offer(0, 95);
        wait_idle(0, 5000);
        check_val("ramp95_dc", int'(dc0), 95);
        offer(0, 120);
        wait_idle(0, 1000);
        check_val("clamp100_dc", int'(dc0), 100);

        // equal target: done next cycle, no ramp
        offer(0, 40);
        wait_idle(0, 5000);
        offer(0, 40);
        check_val("eq_done", int'(done0), 1);
        check_val("eq_dc", int'(dc0), 40);
        check_val("eq_ready", int'(rdy0), 1);
        cycle();
        check_val("eq_done_clear", int'(done0), 0);

        // instance 1: reach 100, then descend to 3 every third wrap
        wait_idle(1, 20000);
        check_val("div3_up_dc", int'(dc1), 100);
        offer(1, 3);
        wait_idle(1, 20000);
        check_val("div3_down_dc", int'(dc1), 3);

        // fault during a downward ramp at dc=15
        offer(0, 0);
        wait_dc(0, 15, 3000);
        fi[0] = 1'b1;
        cycle();
        fi[0] = 1'b0;
        if (FEN) begin
            check_val("fault_dc", int'(dc0), 0);
            check_val("fault_sts", int'(fs0), 1);
            for (int k = 0; k < 5; k++) cycle();
            fc[0] = 1'b1;
            cycle();
            fc[0] = 1'b0;
            check_val("fault_clr_ready", int'(rdy0), 1);
            check_val("fault_clr_sts", int'(fs0), 0);
        end else begin
            check_val("nofault_sts", int'(fs0), 0);
            wait_idle(0, 2000);
        end

        // reset mid-ramp at dc=30
        offer(0, 100);
        wait_dc(0, 30, 3000);
        rst_n[0] = 1'b0;
        model_reset(0);
        #1;
        check_val("midrst_dc", int'(dc0), 0);
        check_val("midrst_busy", int'(busy0), 0);
        cycle();
        rst_n[0] = 1'b1;
        #1;
        check_val("postrst_ready", int'(rdy0), 1);
        for (int k = 0; k < 600; k++) cycle();

        // randomized traffic on both instances
        for (int k = 0; k < 12000; k++) begin
            for (int i = 0; i < 2; i++) begin
                tv[i] = ($urandom_range(0, 3) == 0);
                td[i] = 7'($urandom_range(0, 127));
                fi[i] = ($urandom_range(0, 499) == 0);
                fc[i] = ($urandom_range(0, 7) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
